// File: rtl/core_run_controller_pkg.sv
// Shared encodings for the debug run/step/breakpoint controller.
package core_run_controller_pkg;

  localparam int NUM_REGS = 32;
  localparam int IDX_W    = 5;

  // Host command encodings; 6 and 7 are undefined and behave as NOP.
  typedef enum logic [2:0] {
    CMD_NOP       = 3'd0,
    CMD_RUN       = 3'd1,
    CMD_HALT      = 3'd2,
    CMD_STEP      = 3'd3,
    CMD_RESET_CPU = 3'd4,
    CMD_DUMP      = 3'd5
  } cmd_e;

  // Controller states.
  typedef enum logic [2:0] {
    ST_CPU_RST  = 3'd0,
    ST_HALTED   = 3'd1,
    ST_RUNNING  = 3'd2,
    ST_STEP     = 3'd3,
    ST_DUMP     = 3'd4
  } state_e;

  // Why the core last stopped.
  typedef enum logic [1:0] {
    HR_RESET      = 2'd0,
    HR_HALT_CMD   = 2'd1,
    HR_STEP       = 2'd2,
    HR_BREAKPOINT = 2'd3
  } halt_reason_e;

endpackage

// File: rtl/core_run_controller_reg_dump_seq.sv
// Register snapshot sequencer: walks indices 0..NUM_REGS-1 with a
// valid/ready handshake. start arms it at index 0; done pulses on the
// accepted transfer of the last register.
module reg_dump_seq
  import core_run_controller_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ready,
  output logic             valid,
  output logic [IDX_W-1:0] index,
  output logic             done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  logic             active_r;
  logic [IDX_W-1:0] idx_r;
  logic             xfer_s;

  assign xfer_s = active_r && ready;
  assign valid  = active_r;
  assign index  = idx_r;
  assign done   = xfer_s && (idx_r == LAST_IDX);

  // Index counter and active flag; advancing only on accepted transfers
  // keeps the presented word stable while the host stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_r <= 1'b0;
      idx_r    <= {IDX_W{1'b0}};
    end else if (start) begin
      active_r <= 1'b1;
      idx_r    <= {IDX_W{1'b0}};
    end else if (done) begin
      active_r <= 1'b0;
      idx_r    <= {IDX_W{1'b0}};
    end else if (xfer_s) begin
      idx_r    <= idx_r + IDX_W'(1);
    end
  end

endmodule

// File: rtl/core_run_controller.sv
// Debug run/step/breakpoint controller for the single-cycle RV32 core.
// Gates execution via cpu_en, sequences core reset, stops on a PC
// breakpoint and streams a register file snapshot while halted.
module core_run_controller
  import core_run_controller_pkg::*;
#(
  parameter int RST_CYCLES = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  input  logic [2:0]           cmd,
  output logic                 cmd_ready,
  input  logic                 bp_en,
  input  logic [31:0]          bp_addr,
  input  logic [31:0]          PC,
  output logic [4:0]           Debug_Source_select,
  input  logic [31:0]          Debug_out,
  output logic                 cpu_en,
  output logic                 cpu_reset,
  output logic                 dump_valid,
  input  logic                 dump_ready,
  output logic [4:0]           dump_index,
  output logic [31:0]          dump_data,
  output logic                 halted,
  output logic [1:0]           halt_reason,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_RELOAD = RST_W'(RST_CYCLES - 1);

  state_e               state_r, state_n_s;
  halt_reason_e         halt_reason_r, halt_reason_n_s;
  logic [RST_W-1:0]     rst_cnt_r;
  logic [CNT_WIDTH-1:0] instr_count_r;
  logic                 resume_r, resume_n_s;
  logic                 cmd_acc_s;
  logic                 bp_hit_s;
  logic                 enter_rst_s;
  logic                 dump_start_s;
  logic                 dump_done_s;
  logic [IDX_W-1:0]     dump_idx_s;

  assign cmd_ready   = (state_r == ST_HALTED) || (state_r == ST_RUNNING);
  assign cmd_acc_s   = cmd_valid && cmd_ready;
  // resume masks the breakpoint for the first RUNNING cycle so a RUN
  // issued while sitting on the breakpoint PC executes that instruction.
  assign bp_hit_s    = (state_r == ST_RUNNING) && bp_en && (PC == bp_addr) && !resume_r;
  assign enter_rst_s = (state_n_s == ST_CPU_RST) && (state_r != ST_CPU_RST);

  reg_dump_seq u_dump_seq (
    .clk   (clk),
    .reset (reset),
    .start (dump_start_s),
    .ready (dump_ready),
    .valid (dump_valid),
    .index (dump_idx_s),
    .done  (dump_done_s)
  );

  assign dump_index          = dump_idx_s;
  assign dump_data           = Debug_out;
  assign Debug_Source_select = (state_r == ST_DUMP) ? dump_idx_s : 5'd0;
  assign halted              = (state_r == ST_HALTED);
  assign halt_reason         = halt_reason_r;
  assign instr_count         = instr_count_r;

  // Next-state, core gating and halt-reason selection.
  always_comb begin
    state_n_s       = state_r;
    halt_reason_n_s = halt_reason_r;
    resume_n_s      = 1'b0;
    dump_start_s    = 1'b0;
    cpu_en          = 1'b0;
    cpu_reset       = 1'b0;
    case (state_r)
      ST_CPU_RST: begin
        cpu_reset = 1'b1;
        if (rst_cnt_r == {RST_W{1'b0}}) begin
          state_n_s = ST_HALTED;
        end else begin
          state_n_s = ST_CPU_RST;
        end
      end
      ST_HALTED: begin
        if (cmd_acc_s) begin
          case (cmd)
            CMD_RUN: begin
              state_n_s  = ST_RUNNING;
              resume_n_s = 1'b1;
            end
            CMD_STEP: begin
              state_n_s = ST_STEP;
            end
            CMD_DUMP: begin
              state_n_s    = ST_DUMP;
              dump_start_s = 1'b1;
            end
            CMD_RESET_CPU: begin
              state_n_s       = ST_CPU_RST;
              halt_reason_n_s = HR_RESET;
            end
            default: begin
              state_n_s = ST_HALTED;
            end
          endcase
        end else begin
          state_n_s = ST_HALTED;
        end
      end
      ST_RUNNING: begin
        // A core reset request outranks the breakpoint so an accepted
        // RESET_CPU is never dropped.
        if (cmd_acc_s && (cmd == CMD_RESET_CPU)) begin
          cpu_en          = 1'b0;
          state_n_s       = ST_CPU_RST;
          halt_reason_n_s = HR_RESET;
        end else if (bp_hit_s) begin
          cpu_en          = 1'b0;
          state_n_s       = ST_HALTED;
          halt_reason_n_s = HR_BREAKPOINT;
        end else if (cmd_acc_s && (cmd == CMD_HALT)) begin
          cpu_en          = 1'b1;
          state_n_s       = ST_HALTED;
          halt_reason_n_s = HR_HALT_CMD;
        end else begin
          cpu_en    = 1'b1;
          state_n_s = ST_RUNNING;
        end
      end
      ST_STEP: begin
        cpu_en          = 1'b1;
        state_n_s       = ST_HALTED;
        halt_reason_n_s = HR_STEP;
      end
      ST_DUMP: begin
        if (dump_done_s) begin
          state_n_s = ST_HALTED;
        end else begin
          state_n_s = ST_DUMP;
        end
      end
      default: begin
        state_n_s       = ST_CPU_RST;
        halt_reason_n_s = HR_RESET;
      end
    endcase
  end

  // State register plus reset counter, resume flag and retired count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_CPU_RST;
      halt_reason_r <= HR_RESET;
      rst_cnt_r     <= RST_RELOAD;
      resume_r      <= 1'b0;
      instr_count_r <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r       <= state_n_s;
      halt_reason_r <= halt_reason_n_s;
      resume_r      <= resume_n_s;
      if (enter_rst_s) begin
        rst_cnt_r <= RST_RELOAD;
      end else if ((state_r == ST_CPU_RST) && (rst_cnt_r != {RST_W{1'b0}})) begin
        rst_cnt_r <= rst_cnt_r - RST_W'(1);
      end
      if (enter_rst_s) begin
        instr_count_r <= {CNT_WIDTH{1'b0}};
      end else if (cpu_en) begin
        instr_count_r <= instr_count_r + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_core_run_controller.sv
// Scoreboard bench for core_run_controller: stimulus pushes expected
// status snapshots and dump words; a negedge monitor pops and compares.
module tb_core_run_controller;
  import core_run_controller_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd = 3'd0;
  logic        cmd_ready;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = 32'd0;
  logic [31:0] pc = 32'd0;
  logic [4:0]  dsel;
  logic [31:0] dbg_out;
  logic        cpu_en;
  logic        cpu_reset;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [4:0]  dump_index;
  logic [31:0] dump_data;
  logic        halted;
  logic [1:0]  halt_reason;
  logic [31:0] instr_count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        cpu_reset;
    logic        cpu_en;
    logic        halted;
    logic        dump_valid;
    logic [1:0]  reason;
    logic [31:0] count;
    logic [4:0]  sel;
  } status_t;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } dump_t;

  status_t status_q[$];
  string   name_q[$];
  dump_t   dump_q[$];
  logic    chk_req = 1'b0;

  always #5 clk = ~clk;

  core_run_controller #(.RST_CYCLES(4), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .bp_en(bp_en), .bp_addr(bp_addr), .PC(pc), .Debug_Source_select(dsel),
    .Debug_out(dbg_out), .cpu_en(cpu_en), .cpu_reset(cpu_reset),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_index(dump_index),
    .dump_data(dump_data), .halted(halted), .halt_reason(halt_reason),
    .instr_count(instr_count)
  );

  // Register file model: x_i = 0x100 + i.
  assign dbg_out = 32'h100 + {27'd0, dsel};

  // Core PC model: +4 per enabled cycle, cleared by cpu_reset.
  always @(posedge clk) begin
    if (cpu_reset) pc <= 32'd0;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  // Monitor: compare dump handshakes and requested status snapshots.
  always @(negedge clk) begin
    dump_t   ed;
    status_t es;
    status_t as;
    string   nm;
    if (dump_valid && dump_ready) begin
      vectors++;
      if (dump_q.size() == 0) begin
        miscompares++;
        $display("FAIL dump_extra: got idx %0d data %h, expected no transfer", dump_index, dump_data);
      end else begin
        ed = dump_q.pop_front();
        if (dump_index !== ed.idx || dump_data !== ed.data) begin
          miscompares++;
          $display("FAIL dump_word: got idx %0d data %h, expected idx %0d data %h",
                   dump_index, dump_data, ed.idx, ed.data);
        end
      end
    end
    if (chk_req) begin
      vectors++;
      es = status_q.pop_front();
      nm = name_q.pop_front();
      as.cpu_reset  = cpu_reset;
      as.cpu_en     = cpu_en;
      as.halted     = halted;
      as.dump_valid = dump_valid;
      as.reason     = halt_reason;
      as.count      = instr_count;
      as.sel        = dsel;
      if (as !== es) begin
        miscompares++;
        $display("FAIL %s: got rst=%b en=%b halted=%b dv=%b reason=%0d cnt=%0d sel=%0d, expected rst=%b en=%b halted=%b dv=%b reason=%0d cnt=%0d sel=%0d",
                 nm, as.cpu_reset, as.cpu_en, as.halted, as.dump_valid, as.reason, as.count, as.sel,
                 es.cpu_reset, es.cpu_en, es.halted, es.dump_valid, es.reason, es.count, es.sel);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string nm, input logic cr, input logic ce, input logic h,
                              input logic dv, input logic [1:0] rsn, input logic [31:0] cnt,
                              input logic [4:0] sel);
    status_t s;
    s.cpu_reset = cr; s.cpu_en = ce; s.halted = h; s.dump_valid = dv;
    s.reason = rsn; s.count = cnt; s.sel = sel;
    status_q.push_back(s);
    name_q.push_back(nm);
    chk_req = 1'b1;
    tick();
    chk_req = 1'b0;
  endtask

  task automatic send_cmd(input logic [2:0] c);
    cmd = c;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd = 3'd0;
  endtask

  task automatic push_dump(input int n);
    dump_t d;
    for (int i = 0; i < n; i++) begin
      d.idx  = 5'(i);
      d.data = 32'h100 + 32'(i);
      dump_q.push_back(d);
    end
  endtask

  task automatic drain_dump(input string nm, input logic toggle, input int budget);
    int cyc;
    cyc = 0;
    while (dump_q.size() != 0 && cyc < budget) begin
      dump_ready = toggle ? ~dump_ready : 1'b1;
      tick();
      cyc++;
    end
    dump_ready = 1'b0;
    if (dump_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: timeout with %0d words outstanding, expected 0", nm, dump_q.size());
      dump_q.delete();
    end
  endtask

  initial begin
    // 1. reset and core reset sequencing
    #2 reset = 1'b1;
    tick();
    check_status("in_reset", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 5'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) check_status("rst_hold", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 5'd0);
    check_status("post_rst", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 5'd0);

    // 2. single step, then undefined command, then core reset
    send_cmd(CMD_STEP);
    check_status("step_cycle", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 5'd0);
    check_status("step_done", 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'd1, 5'd0);
    check_status("step_once", 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'd1, 5'd0);
    send_cmd(3'd6);
    check_status("undef_cmd", 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'd1, 5'd0);
    send_cmd(CMD_RESET_CPU);
    for (int i = 0; i < 4; i++) check_status("cpu_rst_hold", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 5'd0);
    check_status("cpu_rst_done", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 5'd0);

    // 3. breakpoint at 0x10, then resume through it
    bp_en = 1'b1;
    bp_addr = 32'h10;
    send_cmd(CMD_RUN);
    for (int i = 0; i < 4; i++) check_status("run_pre_bp", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'(i), 5'd0);
    check_status("bp_stop", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd4, 5'd0);
    check_status("bp_halted", 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 32'd4, 5'd0);
    send_cmd(CMD_RUN);
    check_status("resume_bp", 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 32'd4, 5'd0);
    check_status("run_after_bp", 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 32'd5, 5'd0);

    // 4. HALT while running; HALT coincident with breakpoint
    cmd = CMD_HALT; cmd_valid = 1'b1;
    check_status("halt_accept", 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 32'd6, 5'd0);
    cmd_valid = 1'b0;
    check_status("halt_done", 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 32'd7, 5'd0);
    bp_addr = 32'h24;
    send_cmd(CMD_RUN);
    check_status("run_a", 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 32'd7, 5'd0);
    check_status("run_b", 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 32'd8, 5'd0);
    cmd = CMD_HALT; cmd_valid = 1'b1;
    check_status("halt_bp_same", 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 32'd9, 5'd0);
    cmd_valid = 1'b0;
    check_status("halt_bp_reason", 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 32'd9, 5'd0);
    bp_en = 1'b0;

    // 5. full dump with dump_ready toggling
    push_dump(32);
    send_cmd(CMD_DUMP);
    drain_dump("dump_toggle", 1'b1, 400);
    check_status("dump_done", 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 32'd9, 5'd0);

    // 6. reset mid-dump at index 7, then a fresh dump
    push_dump(7);
    send_cmd(CMD_DUMP);
    dump_ready = 1'b1;
    repeat (7) tick();
    reset = 1'b1;
    check_status("abort_dump", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 5'd0);
    vectors++;
    if (dump_q.size() != 0) begin
      miscompares++;
      $display("FAIL dump_partial: got %0d words outstanding, expected 0", dump_q.size());
      dump_q.delete();
    end
    reset = 1'b0;
    dump_ready = 1'b0;
    for (int i = 0; i < 4; i++) check_status("rst_hold2", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 5'd0);
    check_status("post_rst2", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 5'd0);
    push_dump(32);
    send_cmd(CMD_DUMP);
    drain_dump("redump", 1'b0, 100);
    check_status("redump_done", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 5'd0);

    tick();
    vectors++;
    if (status_q.size() != 0 || dump_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: got %0d status and %0d dump entries pending, expected 0 and 0",
               status_q.size(), dump_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
